ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS-lite pipeline, consuming the decode-stage register outputs.
- Performs ALU and effective-address computation and resolves BZ/BEQ/JR.
- Issues a branch redirect plus squash window to fetch/decode, latches HALT, keeps instruction-class statistics.
- Registers all results toward the MEM stage.

Parameters:
FLUSH_DEPTH, 2, cycles of younger instructions squashed after a taken branch/JR
CNT_W, 32, width of each statistics counter (wraps)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_f_id  in  1  decode outputs hold a real instruction
pc_in_f_id  in  32  PC of instruction
pc4_in_f_id  in  32  PC+4 of instruction
opcode_f_id  in  6  opcode (0x00-0x11 as decoded; others illegal)
rs_reg_value_f_id  in  32  rs operand
rt_reg_value_f_id  in  32  rt operand / store data
rd_add_value_f_id  in  5  destination register
i_data_f_id  in  32  sign-extended immediate
branch_f_id  in  1  control-transfer instruction
mem_read_f_id  in  1  load
mem_to_reg_f_id  in  1  load writeback select
mem_write_f_id  in  1  store
alu_result_2_mem  out  32  ALU result or effective address
store_data_2_mem  out  32  store data
rd_add_2_mem  out  5  destination register
reg_write_2_mem  out  1  writeback enable
mem_read_2_mem  out  1  load
mem_to_reg_2_mem  out  1  writeback select
mem_write_2_mem  out  1  store
branch_taken_2_if  out  1  one-cycle redirect pulse
branch_target_2_if  out  32  redirect PC
halted  out  1  sticky halt
cnt_arith, cnt_logic, cnt_mem, cnt_ctrl, cnt_total, cnt_taken  out  CNT_W  statistics

Behaviour:
- All outputs and internal state are registered. Synchronous reset clears every output to 0, flush counter to 0, halted to 0.
- Reset takes priority over everything, including mid-flush and post-halt.
- Effective instruction: eff = valid_f_id & ~halted & (flush_cnt==0). When eff=0, the MEM outputs load as a bubble: all enables 0, data/address 0. Counters hold. No redirect.
- Latency: one cycle, input sample -> *_2_mem / *_2_if valid on the next clock.
- Arithmetic: 32-bit two's complement, wrap on overflow, no trap.
  - ADD/SUB/MUL: rs op rt; MUL gives the low 32 bits of the signed product.
  - *I forms: rs op i_data.
  - OR/AND/XOR(I): bitwise.
- LDW/STW: alu_result = rs + i_data. STW: store_data = rt_reg_value_f_id. Non-store: store_data = 0.
- reg_write_2_mem = 1 for arithmetic, logical and LDW when rd != 0. Writes to r0 are suppressed. STW/BZ/BEQ/JR/HALT: 0.
- mem_read/mem_to_reg/mem_write pass through when eff=1.
- Branch resolution:
  - BZ is taken if rs == 0.
  - BEQ is taken if rs == rt.
  - JR is always taken.
  - BZ/BEQ target = pc_in + (i_data << 2). JR target = rs.
  - When taken: branch_taken_2_if = 1 for exactly one cycle, target registered alongside, flush_cnt loads FLUSH_DEPTH.
  - flush_cnt decrements each cycle while nonzero. A branch arriving while flush_cnt != 0 is squashed and cannot retrigger.
  - Not taken: branch_target_2_if holds its previous value.
- HALT (0x11) with eff=1: halted set next cycle and stays set until reset. The HALT itself produces a bubble and is counted in cnt_ctrl/cnt_total. All later inputs are ignored.
- Illegal opcode with eff=1: treated as a bubble, counted only in cnt_total.
- Counters, incremented once per effective instruction, wrapping at 2^CNT_W:
  - arith: 0x00-0x05
  - logic: 0x06-0x0B
  - mem: 0x0C-0x0D
  - ctrl: 0x0E-0x11
  - total: all
  - taken: taken redirects

Test Plan:
- ADDI rs=5, imm=0xFFFFFFFD, rd=3 -> next cycle alu_result=2, rd_add=3, reg_write=1. Same with rd=0 -> reg_write=0. cnt_arith=2, cnt_total=2.
- MUL rs=0xFFFFFFFE, rt=3 -> alu_result=0xFFFFFFFA. XORI rs=0xF0F0, imm=0x00FF -> 0xF00F. cnt_logic=1.
- STW rs=0x100, imm=8, rt=0xDEAD -> alu_result=0x108, store_data=0xDEAD, mem_write=1, reg_write=0. LDW same -> mem_read=1, mem_to_reg=1, reg_write=1.
- BEQ pc=0x40, rs=rt=7, imm=3 at cycle N -> N+1: branch_taken=1, target=0x4C. Valid ADDs at N+1, N+2 -> bubbles. ADD at N+3 executes. cnt_taken=1. BZ rs=1 -> no redirect.
- JR rs=0x200, followed immediately by BEQ taken -> single redirect to 0x200, second branch squashed, cnt_taken=1.
- HALT then ADDs -> halted=1 thereafter, no MEM enables, counters frozen. Assert reset for one cycle -> halted=0, all counters 0, outputs 0.

Source files
------------

// File: rtl/ex_if.sv
// ex_if: decode-to-execute operand bundle and execute-to-memory/fetch result bundle
interface ex_if #(
  parameter int CNT_W = 32
);
  logic             valid_f_id;
  logic [31:0]      pc_in_f_id;
  logic [31:0]      pc4_in_f_id;
  logic [5:0]       opcode_f_id;
  logic [31:0]      rs_reg_value_f_id;
  logic [31:0]      rt_reg_value_f_id;
  logic [4:0]       rd_add_value_f_id;
  logic [31:0]      i_data_f_id;
  logic             branch_f_id;
  logic             mem_read_f_id;
  logic             mem_to_reg_f_id;
  logic             mem_write_f_id;
  logic [31:0]      alu_result_2_mem;
  logic [31:0]      store_data_2_mem;
  logic [4:0]       rd_add_2_mem;
  logic             reg_write_2_mem;
  logic             mem_read_2_mem;
  logic             mem_to_reg_2_mem;
  logic             mem_write_2_mem;
  logic             branch_taken_2_if;
  logic [31:0]      branch_target_2_if;
  logic             halted;
  logic [CNT_W-1:0] cnt_arith;
  logic [CNT_W-1:0] cnt_logic;
  logic [CNT_W-1:0] cnt_mem;
  logic [CNT_W-1:0] cnt_ctrl;
  logic [CNT_W-1:0] cnt_total;
  logic [CNT_W-1:0] cnt_taken;
  modport master (
    output valid_f_id, pc_in_f_id, pc4_in_f_id, opcode_f_id, rs_reg_value_f_id,
           rt_reg_value_f_id, rd_add_value_f_id, i_data_f_id, branch_f_id,
           mem_read_f_id, mem_to_reg_f_id, mem_write_f_id,
    input  alu_result_2_mem, store_data_2_mem, rd_add_2_mem, reg_write_2_mem,
           mem_read_2_mem, mem_to_reg_2_mem, mem_write_2_mem, branch_taken_2_if,
           branch_target_2_if, halted, cnt_arith, cnt_logic, cnt_mem, cnt_ctrl,
           cnt_total, cnt_taken
  );
  modport slave (
    input  valid_f_id, pc_in_f_id, pc4_in_f_id, opcode_f_id, rs_reg_value_f_id,
           rt_reg_value_f_id, rd_add_value_f_id, i_data_f_id, branch_f_id,
           mem_read_f_id, mem_to_reg_f_id, mem_write_f_id,
    output alu_result_2_mem, store_data_2_mem, rd_add_2_mem, reg_write_2_mem,
           mem_read_2_mem, mem_to_reg_2_mem, mem_write_2_mem, branch_taken_2_if,
           branch_target_2_if, halted, cnt_arith, cnt_logic, cnt_mem, cnt_ctrl,
           cnt_total, cnt_taken
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS-lite execute stage with ALU, branch resolution, squash window, halt and statistics
module ex_stage #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  ex_if.slave bus
);
  localparam int FW = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);
  localparam logic [5:0] OP_ADD = 6'h00, OP_ADDI = 6'h01, OP_SUB = 6'h02, OP_SUBI = 6'h03;
  localparam logic [5:0] OP_MUL = 6'h04, OP_MULI = 6'h05, OP_OR = 6'h06, OP_ORI = 6'h07;
  localparam logic [5:0] OP_AND = 6'h08, OP_ANDI = 6'h09, OP_XOR = 6'h0A, OP_XORI = 6'h0B;
  localparam logic [5:0] OP_LDW = 6'h0C, OP_STW = 6'h0D, OP_BZ = 6'h0E, OP_BEQ = 6'h0F;
  localparam logic [5:0] OP_JR = 6'h10, OP_HALT = 6'h11;
  logic [5:0]       op;
  logic [31:0]      rs, rt, imm, res;
  logic             eff, is_arith, is_logic, is_mem, is_ctrl, act, taken;
  logic [31:0]      alu_d, alu_q, sd_d, sd_q, tgt_d, tgt_q;
  logic [4:0]       rd_d, rd_q;
  logic             rw_d, rw_q, mr_d, mr_q, mtr_d, mtr_q, mw_d, mw_q;
  logic             bt_d, bt_q, halted_d, halted_q;
  logic [FW-1:0]    flush_d, flush_q;
  logic [CNT_W-1:0] c_ar_d, c_ar_q, c_lo_d, c_lo_q, c_me_d, c_me_q;
  logic [CNT_W-1:0] c_ct_d, c_ct_q, c_to_d, c_to_q, c_tk_d, c_tk_q;
  logic             unused_in;
  assign op  = bus.opcode_f_id;
  assign rs  = bus.rs_reg_value_f_id;
  assign rt  = bus.rt_reg_value_f_id;
  assign imm = bus.i_data_f_id;
  // Branch class comes from the opcode; the decoder's branch flag and PC+4 are redundant here.
  assign unused_in = ^{bus.pc4_in_f_id, bus.branch_f_id};
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:         res = rs + rt;
      OP_ADDI:        res = rs + imm;
      OP_SUB:         res = rs - rt;
      OP_SUBI:        res = rs - imm;
      OP_MUL:         res = rs * rt;
      OP_MULI:        res = rs * imm;
      OP_OR:          res = rs | rt;
      OP_ORI:         res = rs | imm;
      OP_AND:         res = rs & rt;
      OP_ANDI:        res = rs & imm;
      OP_XOR:         res = rs ^ rt;
      OP_XORI:        res = rs ^ imm;
      OP_LDW, OP_STW: res = rs + imm;
      default:        res = '0;
    endcase
  end
  always_comb begin
    eff      = bus.valid_f_id & ~halted_q & (flush_q == '0);
    is_arith = op <= OP_MULI;
    is_logic = (op >= OP_OR) & (op <= OP_XORI);
    is_mem   = (op == OP_LDW) | (op == OP_STW);
    is_ctrl  = (op >= OP_BZ) & (op <= OP_HALT);
    act      = eff & (is_arith | is_logic | is_mem);
    taken    = eff & (((op == OP_BZ) & (rs == '0)) | ((op == OP_BEQ) & (rs == rt)) | (op == OP_JR));
    alu_d    = act ? res : '0;
    sd_d     = (act & (op == OP_STW)) ? rt : '0;
    rd_d     = act ? bus.rd_add_value_f_id : '0;
    rw_d     = act & (op != OP_STW) & (bus.rd_add_value_f_id != '0);
    mr_d     = act & bus.mem_read_f_id;
    mtr_d    = act & bus.mem_to_reg_f_id;
    mw_d     = act & bus.mem_write_f_id;
    bt_d     = taken;
    tgt_d    = taken ? ((op == OP_JR) ? rs : bus.pc_in_f_id + (imm << 2)) : tgt_q;
    flush_d  = taken ? FW'(FLUSH_DEPTH) : ((flush_q != '0) ? flush_q - 1'b1 : '0);
    halted_d = halted_q | (eff & (op == OP_HALT));
    c_ar_d   = c_ar_q + CNT_W'(eff & is_arith);
    c_lo_d   = c_lo_q + CNT_W'(eff & is_logic);
    c_me_d   = c_me_q + CNT_W'(eff & is_mem);
    c_ct_d   = c_ct_q + CNT_W'(eff & is_ctrl);
    c_to_d   = c_to_q + CNT_W'(eff);
    c_tk_d   = c_tk_q + CNT_W'(taken);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q    <= '0;
      sd_q     <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mtr_q    <= 1'b0;
      mw_q     <= 1'b0;
      bt_q     <= 1'b0;
      tgt_q    <= '0;
      flush_q  <= '0;
      halted_q <= 1'b0;
      c_ar_q   <= '0;
      c_lo_q   <= '0;
      c_me_q   <= '0;
      c_ct_q   <= '0;
      c_to_q   <= '0;
      c_tk_q   <= '0;
    end else begin
      alu_q    <= alu_d;
      sd_q     <= sd_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mtr_q    <= mtr_d;
      mw_q     <= mw_d;
      bt_q     <= bt_d;
      tgt_q    <= tgt_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
      c_ar_q   <= c_ar_d;
      c_lo_q   <= c_lo_d;
      c_me_q   <= c_me_d;
      c_ct_q   <= c_ct_d;
      c_to_q   <= c_to_d;
      c_tk_q   <= c_tk_d;
    end
  end
  assign bus.alu_result_2_mem   = alu_q;
  assign bus.store_data_2_mem   = sd_q;
  assign bus.rd_add_2_mem       = rd_q;
  assign bus.reg_write_2_mem    = rw_q;
  assign bus.mem_read_2_mem     = mr_q;
  assign bus.mem_to_reg_2_mem   = mtr_q;
  assign bus.mem_write_2_mem    = mw_q;
  assign bus.branch_taken_2_if  = bt_q;
  assign bus.branch_target_2_if = tgt_q;
  assign bus.halted             = halted_q;
  assign bus.cnt_arith          = c_ar_q;
  assign bus.cnt_logic          = c_lo_q;
  assign bus.cnt_mem            = c_me_q;
  assign bus.cnt_ctrl           = c_ct_q;
  assign bus.cnt_total          = c_to_q;
  assign bus.cnt_taken          = c_tk_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for the execute stage
module tb_ex_stage;
  localparam logic [5:0] ADD = 6'h00, ADDI = 6'h01, MUL = 6'h04, XORI = 6'h0B, LDW = 6'h0C;
  localparam logic [5:0] STW = 6'h0D, BZ = 6'h0E, BEQ = 6'h0F, JR = 6'h10, HALT = 6'h11, ILL = 6'h3F;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  typedef struct {
    logic [31:0] alu, sd, tgt;
    logic [4:0]  rd;
    logic        rw, mr, mtr, mw, bt, h;
  } exp_t;
  exp_t sb[$];
  ex_if #(.CNT_W(32)) bus ();
  ex_stage #(.FLUSH_DEPTH(2), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic [31:0] alu, sd, input logic [4:0] rd,
                              input logic rw, mr, mtr, mw, bt, input logic [31:0] tgt, input logic h);
    exp_t e;
    e.alu = alu; e.sd = sd; e.rd = rd; e.rw = rw; e.mr = mr; e.mtr = mtr;
    e.mw = mw; e.bt = bt; e.tgt = tgt; e.h = h;
    return e;
  endfunction
  function automatic exp_t bub(input logic [31:0] tgt, input logic h);
    return mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tgt, h);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [5:0] op, input logic [31:0] pc, rs, rt, imm,
                     input logic [4:0] rd, input logic br, mr, mtr, mw);
    bus.valid_f_id = v; bus.opcode_f_id = op; bus.pc_in_f_id = pc; bus.pc4_in_f_id = pc + 32'd4;
    bus.rs_reg_value_f_id = rs; bus.rt_reg_value_f_id = rt; bus.i_data_f_id = imm;
    bus.rd_add_value_f_id = rd; bus.branch_f_id = br; bus.mem_read_f_id = mr;
    bus.mem_to_reg_f_id = mtr; bus.mem_write_f_id = mw;
  endtask
  task automatic step(input string nm, input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({nm, ".alu"}, bus.alu_result_2_mem, x.alu);
    chk({nm, ".store"}, bus.store_data_2_mem, x.sd);
    chk({nm, ".rd"}, {27'd0, bus.rd_add_2_mem}, {27'd0, x.rd});
    chk({nm, ".flags"}, {25'd0, bus.reg_write_2_mem, bus.mem_read_2_mem, bus.mem_to_reg_2_mem,
        bus.mem_write_2_mem, bus.branch_taken_2_if, bus.halted, 1'b0},
        {25'd0, x.rw, x.mr, x.mtr, x.mw, x.bt, x.h, 1'b0});
    chk({nm, ".target"}, bus.branch_target_2_if, x.tgt);
  endtask
  task automatic cnts(input string nm, input int a, l, m, c, t, k);
    chk({nm, ".cnt_arith"}, bus.cnt_arith, 32'(a));
    chk({nm, ".cnt_logic"}, bus.cnt_logic, 32'(l));
    chk({nm, ".cnt_mem"}, bus.cnt_mem, 32'(m));
    chk({nm, ".cnt_ctrl"}, bus.cnt_ctrl, 32'(c));
    chk({nm, ".cnt_total"}, bus.cnt_total, 32'(t));
    chk({nm, ".cnt_taken"}, bus.cnt_taken, 32'(k));
  endtask
  initial begin
    drv(1, ADD, 32'h0, 32'h1, 32'h1, 32'h0, 5'd2, 0, 0, 0, 0);
    step("reset", bub(32'h0, 0));
    cnts("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    drv(1, ADDI, 32'h0, 32'h5, 32'h0, 32'hFFFF_FFFD, 5'd3, 0, 0, 0, 0);
    step("addi_r3", mk(32'h2, 32'h0, 5'd3, 1, 0, 0, 0, 0, 32'h0, 0));
    drv(1, ADDI, 32'h0, 32'h5, 32'h0, 32'hFFFF_FFFD, 5'd0, 0, 0, 0, 0);
    step("addi_r0", mk(32'h2, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0, 0));
    cnts("addi", 2, 0, 0, 0, 2, 0);
    drv(1, MUL, 32'h0, 32'hFFFF_FFFE, 32'h3, 32'h0, 5'd4, 0, 0, 0, 0);
    step("mul", mk(32'hFFFF_FFFA, 32'h0, 5'd4, 1, 0, 0, 0, 0, 32'h0, 0));
    drv(1, XORI, 32'h0, 32'h0000_F0F0, 32'h0, 32'h0000_00FF, 5'd5, 0, 0, 0, 0);
    step("xori", mk(32'h0000_F00F, 32'h0, 5'd5, 1, 0, 0, 0, 0, 32'h0, 0));
    cnts("xori", 3, 1, 0, 0, 4, 0);
    drv(1, STW, 32'h0, 32'h100, 32'hDEAD, 32'h8, 5'd0, 0, 0, 0, 1);
    step("stw", mk(32'h108, 32'hDEAD, 5'd0, 0, 0, 0, 1, 0, 32'h0, 0));
    drv(1, LDW, 32'h0, 32'h100, 32'hDEAD, 32'h8, 5'd6, 0, 1, 1, 0);
    step("ldw", mk(32'h108, 32'h0, 5'd6, 1, 1, 1, 0, 0, 32'h0, 0));
    cnts("ldw", 3, 1, 2, 0, 6, 0);
    drv(1, BZ, 32'h30, 32'h1, 32'h0, 32'h4, 5'd0, 1, 0, 0, 0);
    step("bz_nt", bub(32'h0, 0));
    drv(1, BEQ, 32'h40, 32'h7, 32'h7, 32'h3, 5'd0, 1, 0, 0, 0);
    step("beq_t", mk(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 32'h4C, 0));
    drv(1, ADD, 32'h44, 32'h1, 32'h1, 32'h0, 5'd2, 0, 0, 0, 0);
    step("squash1", bub(32'h4C, 0));
    step("squash2", bub(32'h4C, 0));
    drv(1, ADD, 32'h4C, 32'h1, 32'h2, 32'h0, 5'd2, 0, 0, 0, 0);
    step("post_flush", mk(32'h3, 32'h0, 5'd2, 1, 0, 0, 0, 0, 32'h4C, 0));
    cnts("beq", 4, 1, 2, 2, 9, 1);
    drv(1, JR, 32'h50, 32'h200, 32'h0, 32'h0, 5'd0, 1, 0, 0, 0);
    step("jr", mk(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 32'h200, 0));
    drv(1, BEQ, 32'h80, 32'h0, 32'h0, 32'h1, 5'd0, 1, 0, 0, 0);
    step("beq_squashed", bub(32'h200, 0));
    drv(1, ADD, 32'h84, 32'h1, 32'h1, 32'h0, 5'd2, 0, 0, 0, 0);
    step("jr_squash2", bub(32'h200, 0));
    cnts("jr", 4, 1, 2, 3, 10, 2);
    drv(1, ILL, 32'h90, 32'h1, 32'h1, 32'h0, 5'd2, 0, 1, 1, 1);
    step("illegal", bub(32'h200, 0));
    cnts("illegal", 4, 1, 2, 3, 11, 2);
    drv(0, ADD, 32'h94, 32'h1, 32'h1, 32'h0, 5'd2, 0, 0, 0, 0);
    step("invalid", bub(32'h200, 0));
    cnts("invalid", 4, 1, 2, 3, 11, 2);
    drv(1, HALT, 32'h98, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    step("halt", bub(32'h200, 1));
    cnts("halt", 4, 1, 2, 4, 12, 2);
    drv(1, LDW, 32'h9C, 32'h100, 32'h0, 32'h4, 5'd7, 0, 1, 1, 0);
    step("post_halt_ldw", bub(32'h200, 1));
    drv(1, BEQ, 32'hA0, 32'h5, 32'h5, 32'h2, 5'd0, 1, 0, 0, 0);
    step("post_halt_beq", bub(32'h200, 1));
    cnts("post_halt", 4, 1, 2, 4, 12, 2);
    reset = 1'b1;
    drv(1, ADD, 32'hA4, 32'h1, 32'h1, 32'h0, 5'd2, 0, 0, 0, 0);
    step("reset2", bub(32'h0, 0));
    cnts("reset2", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    drv(1, ADD, 32'hA8, 32'h1, 32'h2, 32'h0, 5'd2, 0, 0, 0, 0);
    step("after_reset", mk(32'h3, 32'h0, 5'd2, 1, 0, 0, 0, 0, 32'h0, 0));
    cnts("after_reset", 1, 0, 0, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
